simmem_delay_releaser: RTL and testbench
========================================

Name: simmem_delay_releaser

Overview:
- Timing stage that produces the per-ID release enables consumed by the simmem linked-list response bank.
- Each accepted request (ID plus programmed delay) occupies one tracking slot and counts down its delay.
- When a slot's delay has expired and the slot is the oldest pending one for its ID, release_en_o[ID] rises.
- The bank's output handshake for that ID retires the slot. Per-ID order is preserved.

Parameters:
- IDWidth, 4, width of the transaction ID; release_en_o has 2**IDWidth bits.
- NumSlots, 16, number of concurrently tracked pending requests.
- DelayWidth, 8, width of the delay field and of the per-slot down-counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  new request to track
- req_ready_o  out  1  at least one free slot
- req_id_i  in  IDWidth  ID of the new request
- req_delay_i  in  DelayWidth  delay in cycles for the new request
- release_en_o  out  2**IDWidth  per-ID release enable, drives bank release_en_i
- rsp_valid_i  in  1  bank out_valid_o (observed)
- rsp_ready_i  in  1  downstream out_ready_i (observed)
- rsp_id_i  in  IDWidth  ID field of the bank data_o

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low on rst_ni.
- Reset values: all slots invalid; release_en_o = 0; req_ready_o = 1.
- Slot state: valid, id, counter[DelayWidth], rank[$clog2(NumSlots)].
  - rank is the number of older valid slots with the same ID.
  - The slot with rank 0 is that ID's head.
- Accept:
  - Occurs when req_valid_i && req_ready_o.
  - Allocates the lowest-index invalid slot (priority encoder) with counter = req_delay_i and id = req_id_i.
  - rank = count of valid slots with the same ID, minus 1 if a retire of that ID happens in the same cycle.
- Countdown:
  - Every cycle, each valid slot with counter > 0 decrements by 1.
  - At counter == 0 the counter holds (saturating; no wrap).
  - The counter is not loaded and decremented in the same cycle.
- Release:
  - release_en_o[i] = OR over slots of (valid && id == i && rank == 0 && counter == 0). It is registered-state only, with no combinational path from req_*.
  - Latency: a request accepted at edge E with delay d can first assert release_en_o at cycle E+1+d, provided older same-ID slots are already retired.
  - Delay 0 asserts release_en_o in the cycle after acceptance.
- Retire:
  - Occurs when rsp_valid_i && rsp_ready_i.
  - The head slot of rsp_id_i (rank 0, counter 0) is invalidated.
  - Every other valid slot with id == rsp_id_i has rank decremented by 1.
  - Other IDs are untouched.
- Per-ID ordering: a later same-ID request that expires first waits at counter 0 until it becomes head.
- Full: req_ready_o = |~valid.
  - A slot freed by a retire becomes allocatable from the next cycle only; there is no same-cycle reuse and no ready-through-retire path.
- Simultaneous accept and retire of the same ID in one cycle: both are applied, and the new slot's rank is computed as above.
- Illegal retire (no expired head for rsp_id_i): ignored, state unchanged. An assertion fires in simulation.
- Reset mid-operation: all slots are dropped immediately. The bank must be reset on the same rst_ni.

Optional Feature:
- Macro: SIMMEM_RELEASER_OCCUPANCY_EN.
- When defined:
  - Adds output occupancy_o[$clog2(NumSlots+1)], the registered count of valid slots, reset 0.
  - Adds output max_occupancy_o, the highest occupancy since reset, reset 0.
- When undefined: neither port exists and no counters are synthesised.

Test Plan:
- Single request, id=3, delay=5, accepted at cycle 0 → release_en_o = 16'h0008 from cycle 6; retire of id 3 at cycle 8 → release_en_o = 0 at cycle 9, req_ready_o stays 1.
- Same-ID ordering: id=2 with delay=10 at cycle 0, then id=2 with delay=1 at cycle 1 → release_en_o[2] stays 0 until cycle 11; after the first retire it stays 1 (second slot already expired) until the second retire.
- Independent IDs: id=1 delay=4 and id=7 delay=2 on consecutive cycles → bit 7 at cycle 4 and bit 1 at cycle 5, each cleared only by its own retire.
- Full: fill 16 slots with delay=255 → req_ready_o = 0 in the cycle after the 16th accept; a retire enables one more accept on the following cycle, not the same cycle.
- Delay 0 plus simultaneous accept/retire: id=5 head expired, new id=5 delay=0 accepted in the same cycle as the head retire → new slot rank 0, release_en_o[5] = 1 the next cycle.
- Reset: assert rst_ni low asynchronously with 3 pending slots → release_en_o = 0 and req_ready_o = 1 immediately; no stale releases after deassertion.

Source files
------------

// File: rtl/simmem_delay_releaser.sv
`default_nettype none
// ============================================================================
// Module   : simmem_delay_releaser
// Brief    : Per-slot delay countdown producing per-ID release enables for the
//            simmem linked-list response bank, preserving per-ID order.
//            Optional occupancy counters: SIMMEM_RELEASER_OCCUPANCY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module simmem_delay_releaser #(
  parameter int IDWidth    = 4,
  parameter int NumSlots   = 16,
  parameter int DelayWidth = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [IDWidth-1:0]                req_id_i,
  input  logic [DelayWidth-1:0]             req_delay_i,
  output logic [2**IDWidth-1:0]             release_en_o,
  input  logic                              rsp_valid_i,
  input  logic                              rsp_ready_i,
  input  logic [IDWidth-1:0]                rsp_id_i
`ifdef SIMMEM_RELEASER_OCCUPANCY_EN
  ,
  output logic [$clog2(NumSlots+1)-1:0]     occupancy_o,
  output logic [$clog2(NumSlots+1)-1:0]     max_occupancy_o
`endif
);

  localparam int C_IDX_W  = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam int C_RANK_W = C_IDX_W;

  // Slot state
  logic [NumSlots-1:0]   r_valid;
  logic [IDWidth-1:0]    r_id   [NumSlots];
  logic [DelayWidth-1:0] r_cnt  [NumSlots];
  logic [C_RANK_W-1:0]   r_rank [NumSlots];

  logic                  w_accept;
  logic                  w_rsp_fire;
  logic                  w_retire;
  logic [NumSlots-1:0]   w_head_hit;
  logic [NumSlots-1:0]   w_rsp_match;
  logic [NumSlots-1:0]   w_req_match;
  logic [C_IDX_W-1:0]    w_free_idx;
  logic [C_RANK_W-1:0]   w_same_cnt;
  logic [C_RANK_W-1:0]   w_new_rank;

  generate
    for (genvar s = 0; s < NumSlots; s++) begin : g_slot_match
      assign w_rsp_match[s] = r_valid[s] && (r_id[s] == rsp_id_i);
      assign w_req_match[s] = r_valid[s] && (r_id[s] == req_id_i);
      assign w_head_hit[s]  = w_rsp_match[s] && (r_rank[s] == '0) && (r_cnt[s] == '0);
    end
  endgenerate

  assign req_ready_o = |(~r_valid);
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_rsp_fire  = rsp_valid_i && rsp_ready_i;
  // A handshake without an expired head is dropped entirely, ranks included.
  assign w_retire    = w_rsp_fire && (|w_head_hit);

  always_comb begin
    w_free_idx = '0;
    for (int s = NumSlots - 1; s >= 0; s--) begin
      if (!r_valid[s]) begin
        w_free_idx = C_IDX_W'(s);
      end
    end
  end

  // Count can only reach NumSlots when full, in which case nothing is accepted.
  always_comb begin
    w_same_cnt = '0;
    for (int s = 0; s < NumSlots; s++) begin
      w_same_cnt = w_same_cnt + C_RANK_W'(w_req_match[s]);
    end
    w_new_rank = w_same_cnt - C_RANK_W'(w_retire && (rsp_id_i == req_id_i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      for (int s = 0; s < NumSlots; s++) begin
        r_id[s]   <= '0;
        r_cnt[s]  <= '0;
        r_rank[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NumSlots; s++) begin
        if (w_accept && (w_free_idx == C_IDX_W'(s))) begin
          r_valid[s] <= 1'b1;
          r_id[s]    <= req_id_i;
          r_cnt[s]   <= req_delay_i;
          r_rank[s]  <= w_new_rank;
        end else if (r_valid[s]) begin
          if (r_cnt[s] != '0) begin
            r_cnt[s] <= r_cnt[s] - DelayWidth'(1);
          end
          if (w_retire && w_rsp_match[s]) begin
            if (w_head_hit[s]) begin
              r_valid[s] <= 1'b0;
            end else begin
              r_rank[s] <= r_rank[s] - C_RANK_W'(1);
            end
          end
        end
      end
    end
  end

  // Decoded from slot registers only; no path from the request inputs.
  always_comb begin
    release_en_o = '0;
    for (int s = 0; s < NumSlots; s++) begin
      if (r_valid[s] && (r_rank[s] == '0) && (r_cnt[s] == '0)) begin
        release_en_o[r_id[s]] = 1'b1;
      end
    end
  end

`ifdef SIMMEM_RELEASER_OCCUPANCY_EN
  localparam int C_OCC_W = $clog2(NumSlots + 1);

  logic [C_OCC_W-1:0] r_occ;
  logic [C_OCC_W-1:0] r_max_occ;
  logic [C_OCC_W-1:0] w_occ_nxt;

  assign w_occ_nxt = r_occ + C_OCC_W'(w_accept) - C_OCC_W'(w_retire);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_occ     <= '0;
      r_max_occ <= '0;
    end else begin
      r_occ <= w_occ_nxt;
      if (w_occ_nxt > r_max_occ) begin
        r_max_occ <= w_occ_nxt;
      end
    end
  end

  assign occupancy_o     = r_occ;
  assign max_occupancy_o = r_max_occ;
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni && w_rsp_fire) begin
      assert (|w_head_hit)
        else $error("simmem_delay_releaser: retire of id %0d without an expired head", rsp_id_i);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_simmem_delay_releaser.sv
`default_nettype none
// ============================================================================
// Module   : tb_simmem_delay_releaser
// Brief    : Scoreboard bench with per-ID expiry queues as reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simmem_delay_releaser;

  localparam int IDW  = 4;
  localparam int NS   = 16;
  localparam int DW   = 8;
  localparam int NIDS = 2**IDW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [IDW-1:0]  req_id;
  logic [DW-1:0]   req_delay;
  logic [NIDS-1:0] release_en;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
`ifdef SIMMEM_RELEASER_OCCUPANCY_EN
  logic [$clog2(NS+1)-1:0] occ;
  logic [$clog2(NS+1)-1:0] max_occ;
`endif

  simmem_delay_releaser #(.IDWidth(IDW), .NumSlots(NS), .DelayWidth(DW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_id_i     (req_id),
    .req_delay_i  (req_delay),
    .release_en_o (release_en),
    .rsp_valid_i  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_i     (rsp_id)
`ifdef SIMMEM_RELEASER_OCCUPANCY_EN
    ,
    .occupancy_o     (occ),
    .max_occupancy_o (max_occ)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: per-ID FIFO of absolute cycles at which each request expires.
  int unsigned exp_q [NIDS][$];
  int unsigned cyc = 0;
  int          model_max = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic int model_total();
    int t = 0;
    for (int i = 0; i < NIDS; i++) t += exp_q[i].size();
    return t;
  endfunction

  function automatic logic [NIDS-1:0] model_rel();
    logic [NIDS-1:0] r = '0;
    for (int i = 0; i < NIDS; i++)
      if (exp_q[i].size() > 0 && exp_q[i][0] <= cyc) r[i] = 1'b1;
    return r;
  endfunction

  function automatic bit expired(input int id);
    return exp_q[id].size() > 0 && exp_q[id][0] <= cyc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model update on each active edge (state before the edge decides readiness).
  always @(posedge clk) begin
    if (rst_n) begin
      bit acc;
      acc = req_valid && (model_total() < NS);
      if (rsp_valid && rsp_ready && exp_q[rsp_id].size() > 0) void'(exp_q[rsp_id].pop_front());
      if (acc) exp_q[req_id].push_back(cyc + 1 + int'(req_delay));
      if (model_total() > model_max) model_max = model_total();
    end
    cyc++;
  end

  // Monitor: compares every DUT output against the model each cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("release_en", 32'(release_en), 32'(model_rel()));
      check("req_ready", 32'(req_ready), 32'(model_total() < NS));
`ifdef SIMMEM_RELEASER_OCCUPANCY_EN
      check("occupancy", 32'(occ), 32'(model_total()));
      check("max_occupancy", 32'(max_occ), 32'(model_max));
`endif
    end
  end

  // sid: -1 no retire, -2 random expired ID with 50% chance, >=0 that ID if legal.
  task automatic step(input bit rv, input int rid, input int rd, input int sid);
    int pick = -1;
    if (sid >= 0 && expired(sid)) pick = sid;
    if (sid == -2 && $urandom_range(0, 1) == 1) begin
      int off = $urandom_range(0, NIDS - 1);
      for (int k = 0; k < NIDS; k++)
        if (pick < 0 && expired((k + off) % NIDS)) pick = (k + off) % NIDS;
    end
    req_valid = rv;
    req_id    = IDW'(rid);
    req_delay = DW'(rd);
    if (pick >= 0) begin
      rsp_valid = 1'b1;
      rsp_ready = 1'b1;
      rsp_id    = IDW'(pick);
    end else begin
      // Non-firing noise on the observed handshake.
      rsp_id    = IDW'($urandom_range(0, NIDS - 1));
      rsp_valid = 1'($urandom_range(0, 1));
      rsp_ready = rsp_valid ? 1'b0 : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input int sid);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, sid);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_id = '0; req_delay = '0;
    rsp_valid = 1'b0; rsp_ready = 1'b0; rsp_id = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single request
    step(1'b1, 3, 5, -1); idle(7, -1); step(1'b0, 0, 0, 3); idle(2, -1);
    // Same-ID ordering
    step(1'b1, 2, 10, -1); step(1'b1, 2, 1, -1); idle(12, -1);
    step(1'b0, 0, 0, 2); idle(3, -1); step(1'b0, 0, 0, 2); idle(2, -1);
    // Independent IDs
    step(1'b1, 1, 4, -1); step(1'b1, 7, 2, -1); idle(6, -1);
    step(1'b0, 0, 0, 7); idle(2, -1); step(1'b0, 0, 0, 1); idle(2, -1);
    // Full, then retire alongside a pending request
    for (int i = 0; i < NS + 3; i++) step(1'b1, i % NIDS, 255, -1);
    for (int i = 0; i < 240; i++) step(1'b1, 9, 3, -1);
    step(1'b1, 9, 3, 0);
    step(1'b1, 9, 3, -1);
    idle(40, -2);
    // Delay 0 accepted while retiring the same ID's expired head
    step(1'b1, 5, 2, -1); idle(4, -1); step(1'b1, 5, 0, 5); idle(2, -1);
    step(1'b0, 0, 0, 5); idle(2, -1);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      int id = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NIDS - 1) : $urandom_range(0, 3);
      int d  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 15);
      step(1'($urandom_range(0, 9) < 5), id, d, -2);
    end

    // Asynchronous reset with pending slots, one of them releasing
    idle(60, -2);
    step(1'b1, 4, 0, -1); step(1'b1, 6, 3, -1); step(1'b1, 4, 1, -1);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset release_en", 32'(release_en), 32'h0);
    check("reset req_ready", 32'(req_ready), 32'h1);
    for (int i = 0; i < NIDS; i++) exp_q[i].delete();
    model_max = 0;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(25, -1);
    step(1'b1, 8, 1, -1); idle(4, -1); step(1'b0, 0, 0, 8); idle(2, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
